// File: rtl/fault_campaign_seq.sv
// Fault-injection campaign sequencer: runs one golden pass, then one faulty pass per
// fault ID in [batch_start, batch_end), and reports a 16-bit signature per fault.
module fault_campaign_seq #(
    parameter int FID_W   = 11,
    parameter int IN_W    = 10,
    parameter int OUT_W   = 11,
    parameter int CYCLES  = 512,
    parameter int PH1_END = 170,
    parameter int PH2_END = 340
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FID_W-1:0] batch_start,
    input  logic [FID_W-1:0] batch_end,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    output logic             fault_en,
    output logic [FID_W-1:0] fault_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FID_W-1:0] res_fid,
    output logic [15:0]      res_sig,
    output logic             res_det,
    output logic             busy,
    output logic             done,
    output logic [FID_W-1:0] det_cnt,
    output logic [2:0]       state_dbg
);

    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GOLDEN = 3'd1,
        S_RUN    = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    c_q, c_d;
    logic [15:0]      sig_q, sig_d;
    logic [15:0]      gold_q, gold_d;
    logic [FID_W:0]   fault_q, fault_d;
    logic [FID_W-1:0] bstart_q, bstart_d;
    logic [FID_W-1:0] bend_q, bend_d;
    logic             rvalid_q, rvalid_d;
    logic [FID_W-1:0] rfid_q, rfid_d;
    logic [15:0]      rsig_q, rsig_d;
    logic             rdet_q, rdet_d;
    logic [FID_W-1:0] det_q, det_d;
    logic [IN_W-1:0]  stim_q, stim_d;

    logic [15:0]      sig_next;
    logic [FID_W:0]   fault_inc;
    logic             pass_last;

    // Stimulus pattern: zeros, then ones, then alternating bits (bit k = k[0]).
    function automatic logic [IN_W-1:0] phase_pattern(input logic [CW-1:0] v);
        logic [IN_W-1:0] p;
        p = '0;
        for (int k = 0; k < IN_W; k++) begin
            if (int'(v) < PH1_END) begin
                p[k] = 1'b0;
            end else if (int'(v) < PH2_END) begin
                p[k] = 1'b1;
            end else begin
                p[k] = k[0];
            end
        end
        return p;
    endfunction

    assign sig_next  = {sig_q[14:0], sig_q[15]} ^ 16'(dut_out);
    assign fault_inc = fault_q + 1'b1;
    assign pass_last = (c_q == C_LAST);

    // Result handshake: res_valid rises on REPORT entry and the payload stays frozen
    // until an edge sees res_valid && res_ready; res_ready outside REPORT is ignored.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        sig_d    = sig_q;
        gold_d   = gold_q;
        fault_d  = fault_q;
        bstart_d = bstart_q;
        bend_d   = bend_q;
        rvalid_d = rvalid_q;
        rfid_d   = rfid_q;
        rsig_d   = rsig_q;
        rdet_d   = rdet_q;
        det_d    = det_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_GOLDEN;
                    bstart_d = batch_start;
                    bend_d   = batch_end;
                    det_d    = '0;
                    c_d      = '0;
                    sig_d    = '0;
                end
            end
            S_GOLDEN: begin
                if (pass_last) begin
                    gold_d = sig_next;
                    c_d    = '0;
                    sig_d  = '0;
                    if (bstart_q < bend_q) begin
                        state_d = S_RUN;
                        fault_d = {1'b0, bstart_q};
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    c_d   = c_q + 1'b1;
                    sig_d = sig_next;
                end
            end
            S_RUN: begin
                if (pass_last) begin
                    state_d  = S_REPORT;
                    c_d      = '0;
                    sig_d    = sig_next;
                    rvalid_d = 1'b1;
                    rfid_d   = fault_q[FID_W-1:0];
                    rsig_d   = sig_next;
                    rdet_d   = (sig_next != gold_q);
                    if ((sig_next != gold_q) && (det_q != '1)) begin
                        det_d = det_q + 1'b1;
                    end
                end else begin
                    c_d   = c_q + 1'b1;
                    sig_d = sig_next;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    rvalid_d = 1'b0;
                    fault_d  = fault_inc;
                    if (fault_inc == {1'b0, bend_q}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        c_d     = '0;
                        sig_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        stim_d = phase_pattern({c_d[CW-1:2], 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            sig_q    <= '0;
            gold_q   <= '0;
            fault_q  <= '0;
            bstart_q <= '0;
            bend_q   <= '0;
            rvalid_q <= 1'b0;
            rfid_q   <= '0;
            rsig_q   <= '0;
            rdet_q   <= 1'b0;
            det_q    <= '0;
            stim_q   <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            sig_q    <= sig_d;
            gold_q   <= gold_d;
            fault_q  <= fault_d;
            bstart_q <= bstart_d;
            bend_q   <= bend_d;
            rvalid_q <= rvalid_d;
            rfid_q   <= rfid_d;
            rsig_q   <= rsig_d;
            rdet_q   <= rdet_d;
            det_q    <= det_d;
            stim_q   <= stim_d;
        end
    end

    assign stim      = stim_q;
    assign fault_en  = (state_q == S_RUN);
    assign fault_id  = fault_q[FID_W-1:0];
    assign res_valid = rvalid_q;
    assign res_fid   = rfid_q;
    assign res_sig   = rsig_q;
    assign res_det   = rdet_q;
    assign busy      = (state_q == S_GOLDEN) || (state_q == S_RUN) || (state_q == S_REPORT);
    assign done      = (state_q == S_DONE);
    assign det_cnt   = det_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fault_campaign_seq.sv
// Bench for fault_campaign_seq: directed campaigns plus randomized fault behaviour,
// with expected signatures computed by a pass-level model of the netlist under test.
module tb_fault_campaign_seq;

    localparam int FID_W   = 11;
    localparam int IN_W    = 10;
    localparam int OUT_W   = 11;
    localparam int CYCLES  = 512;
    localparam int PH1_END = 170;
    localparam int PH2_END = 340;

    logic             clk;
    logic             rst;
    logic             start;
    logic [FID_W-1:0] batch_start;
    logic [FID_W-1:0] batch_end;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] dut_out;
    logic             fault_en;
    logic [FID_W-1:0] fault_id;
    logic             res_valid;
    logic             res_ready;
    logic [FID_W-1:0] res_fid;
    logic [15:0]      res_sig;
    logic             res_det;
    logic             busy;
    logic             done;
    logic [FID_W-1:0] det_cnt;
    logic [2:0]       state_dbg;

    int vectors;
    int miscompares;
    int resp_mode;
    logic [1:0]  fault_kind [0:(1<<FID_W)-1];
    logic [27:0] exp_q[$];

    fault_campaign_seq #(
        .FID_W(FID_W), .IN_W(IN_W), .OUT_W(OUT_W),
        .CYCLES(CYCLES), .PH1_END(PH1_END), .PH2_END(PH2_END)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .batch_start(batch_start), .batch_end(batch_end),
        .stim(stim), .dut_out(dut_out),
        .fault_en(fault_en), .fault_id(fault_id),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_fid(res_fid), .res_sig(res_sig), .res_det(res_det),
        .busy(busy), .done(done), .det_cnt(det_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Netlist model: base response {s[0], s}; the fault kind selects an injected effect.
    function automatic logic [OUT_W-1:0] net_resp(input logic [IN_W-1:0] s, input logic fen,
                                                  input logic [1:0] kind);
        logic [OUT_W-1:0] r;
        r = {s[0], s};
        if (fen) begin
            case (kind)
                2'd1: if (s == '0) r[0] = ~r[0];
                2'd2: if (s == '1) r[10] = ~r[10];
                2'd3: r[3] = ~r[3];
                default: ;
            endcase
        end
        return r;
    endfunction

    assign dut_out = (resp_mode == 0) ? '0 : net_resp(stim, fault_en, fault_kind[fault_id]);

    // Stimulus expected at vector c, straight from the phase rules.
    function automatic logic [IN_W-1:0] exp_stim(input int c);
        int v;
        logic [IN_W-1:0] r;
        v = c - (c % 4);
        r = '0;
        if (v < PH1_END) return '0;
        if (v < PH2_END) return '1;
        for (int k = 0; k < IN_W; k++) if ((k % 2) == 1) r[k] = 1'b1;
        return r;
    endfunction

    // Signature of one full pass for the given fault enable / fault kind.
    function automatic logic [15:0] model_sig(input logic fen, input logic [1:0] kind);
        logic [15:0] s;
        logic [15:0] resp;
        s = '0;
        for (int c = 0; c < CYCLES; c++) begin
            resp = (resp_mode == 0) ? 16'd0 : 16'(net_resp(exp_stim(c), fen, kind));
            s = ((s << 1) | (s >> 15)) ^ resp;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".stim"},      32'(stim),      32'd0);
        chk({tag, ".fault_en"},  32'(fault_en),  32'd0);
        chk({tag, ".fault_id"},  32'(fault_id),  32'd0);
        chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, ".res_fid"},   32'(res_fid),   32'd0);
        chk({tag, ".res_sig"},   32'(res_sig),   32'd0);
        chk({tag, ".res_det"},   32'(res_det),   32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".det_cnt"},   32'(det_cnt),   32'd0);
    endtask

    // One campaign from launch to DONE. wait_n < 0 picks a random REPORT stall 0..3.
    task automatic run_campaign(input int bs, input int be, input int wait_n, input bit stim_all);
        logic [15:0] gold;
        logic [15:0] s;
        logic [27:0] e;
        int expdet;
        int n;
        gold = model_sig(1'b0, 2'd0);
        exp_q.delete();
        expdet = 0;
        for (int f = bs; f < be; f++) begin
            s = model_sig(1'b1, fault_kind[f]);
            exp_q.push_back({11'(f), s, (s != gold)});
        end

        start = 1'b1; batch_start = 11'(bs); batch_end = 11'(be);
        tick();
        start = 1'b0;
        chk("launch.busy", 32'(busy), 32'd1);
        chk("launch.done", 32'(done), 32'd0);
        chk("launch.det_cnt", 32'(det_cnt), 32'd0);
        chk("launch.res_valid", 32'(res_valid), 32'd0);

        for (int k = 0; k < CYCLES; k++) begin
            if (stim_all || k == 0 || k == 339 || k == 340 || k == 343)
                chk("gold.stim", 32'(stim), 32'(exp_stim(k)));
            if (k == 0)   chk("gold.stim0", 32'(stim), 32'h000);
            if (k == 339) chk("gold.stim339", 32'(stim), 32'h3FF);
            if (k == 343) chk("gold.stim343", 32'(stim), 32'h2AA);
            if (k == CYCLES - 1) chk("gold.fault_en", 32'(fault_en), 32'd0);
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end

        if (bs >= be) begin
            res_ready = 1'b0;
            chk("empty.done", 32'(done), 32'd1);
            chk("empty.busy", 32'(busy), 32'd0);
            chk("empty.res_valid", 32'(res_valid), 32'd0);
            chk("empty.det_cnt", 32'(det_cnt), 32'd0);
            tick();
            chk("empty.res_valid2", 32'(res_valid), 32'd0);
            return;
        end

        for (int f = bs; f < be; f++) begin
            for (int k = 0; k < CYCLES; k++) begin
                if (k == 0) begin
                    chk("run.fault_en", 32'(fault_en), 32'd1);
                    chk("run.fault_id", 32'(fault_id), 32'(f));
                    chk("run.res_valid", 32'(res_valid), 32'd0);
                end
                if (stim_all || k == 169 || k == 170 || k == 511)
                    chk("run.stim", 32'(stim), 32'(exp_stim(k)));
                res_ready = 1'($urandom_range(0, 1));
                tick();
            end
            e = exp_q.pop_front();
            expdet += int'(e[0]);
            chk("rep.res_valid", 32'(res_valid), 32'd1);
            chk("rep.res_fid", 32'(res_fid), 32'(e[27:17]));
            chk("rep.res_sig", 32'(res_sig), 32'(e[16:1]));
            chk("rep.res_det", 32'(res_det), 32'(e[0]));
            chk("rep.det_cnt", 32'(det_cnt), 32'(expdet));
            chk("rep.busy", 32'(busy), 32'd1);
            n = (wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n;
            res_ready = 1'b0;
            for (int i = 0; i < n; i++) begin
                tick();
                chk("stall.res_valid", 32'(res_valid), 32'd1);
                chk("stall.res_sig", 32'(res_sig), 32'(e[16:1]));
                chk("stall.res_fid", 32'(res_fid), 32'(e[27:17]));
                chk("stall.res_det", 32'(res_det), 32'(e[0]));
                chk("stall.fault_id", 32'(fault_id), 32'(f));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            if (f == be - 1) begin
                chk("fin.done", 32'(done), 32'd1);
                chk("fin.busy", 32'(busy), 32'd0);
                chk("fin.res_valid", 32'(res_valid), 32'd0);
                chk("fin.det_cnt", 32'(det_cnt), 32'(expdet));
            end else begin
                chk("xfer.res_valid", 32'(res_valid), 32'd0);
                chk("xfer.stim", 32'(stim), 32'd0);
            end
        end
        chk("sb.empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int bs;
        vectors = 0; miscompares = 0; resp_mode = 1;
        for (int i = 0; i < (1 << FID_W); i++) fault_kind[i] = 2'd0;
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        batch_start = '0; batch_end = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_zero("reset");

        // Reset mid-RUN, with a stray start while busy that must be ignored.
        start = 1'b1; batch_start = 11'd0; batch_end = 11'd2;
        tick();
        start = 1'b0;
        repeat (100) tick();
        start = 1'b1; batch_start = 11'd7; batch_end = 11'd9;
        tick();
        start = 1'b0;
        repeat (CYCLES + 200 - 101) tick();
        chk("midrun.fault_en", 32'(fault_en), 32'd1);
        chk("midrun.fault_id", 32'(fault_id), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_run");
        tick();
        chk_zero("rst_run_idle");

        // Reset while a result is pending.
        start = 1'b1; batch_start = 11'd3; batch_end = 11'd5;
        tick();
        start = 1'b0;
        repeat (2 * CYCLES) tick();
        chk("prerst.res_valid", 32'(res_valid), 32'd1);
        chk("prerst.res_fid", 32'(res_fid), 32'd3);
        start = 1'b1; batch_start = 11'd9; batch_end = 11'd10;
        tick();
        start = 1'b0;
        chk("rep_start_ignored.res_fid", 32'(res_fid), 32'd3);
        chk("rep_start_ignored.res_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_report");
        repeat (3) tick();
        chk("postrst.res_valid", 32'(res_valid), 32'd0);

        // Constant-zero response, full stimulus check, always-ready sink.
        resp_mode = 0;
        run_campaign(0, 4, 0, 1'b1);

        // Golden-matching netlist with one observable fault at ID 5, launched from DONE.
        resp_mode = 1;
        fault_kind[5] = 2'd1;
        run_campaign(4, 7, -1, 1'b0);
        chk("batch4_7.det_cnt", 32'(det_cnt), 32'd1);

        // Empty batch.
        run_campaign(9, 9, 0, 1'b0);

        // Back-pressure: 20 stalled cycles in each REPORT.
        fault_kind[10] = 2'd2;
        run_campaign(10, 12, 20, 1'b0);

        // Randomized fault behaviour, including the top of the fault-ID range.
        for (int f = 2045; f < 2047; f++) fault_kind[f] = 2'($urandom_range(0, 3));
        run_campaign(2045, 2047, -1, 1'b0);
        bs = int'($urandom_range(100, 1900));
        for (int f = bs; f < bs + 2; f++) fault_kind[f] = 2'($urandom_range(0, 3));
        run_campaign(bs, bs + 2, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fault_campaign_seq.md
FAULT_CAMPAIGN_SEQ -- requirements
Module: fault_campaign_seq

Interface
REQ-001 The block SHALL have parameter FID_W, default 11, meaning fault-ID width.
REQ-002 The block SHALL have parameter IN_W, default 10, meaning stimulus width to the DUT.
REQ-003 The block SHALL have parameter OUT_W, default 11, meaning DUT response width.
REQ-004 The block SHALL have parameter CYCLES, default 512, meaning vectors per pass.
REQ-005 The block SHALL have parameters PH1_END and PH2_END, defaults 170 and 340, meaning the phase boundaries.
REQ-006 The block SHALL have port clk, input, width 1: the single clock.
REQ-007 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, width 1: campaign launch pulse.
REQ-009 The block SHALL have ports batch_start and batch_end, inputs, width FID_W: first fault ID and exclusive end.
REQ-010 The block SHALL have port stim, output, width IN_W: registered DUT stimulus.
REQ-011 The block SHALL have port dut_out, input, width OUT_W: combinational DUT response.
REQ-012 The block SHALL have ports fault_en (width 1) and fault_id (width FID_W), outputs: drive the netlist fault MUX.
REQ-013 The block SHALL have ports res_valid, output, width 1, and res_ready, input, width 1: per-fault result handshake.
REQ-014 The block SHALL have ports res_fid (FID_W), res_sig (16) and res_det (1), outputs: result payload.
REQ-015 The block SHALL have ports busy and done, outputs, width 1, and det_cnt, output, width FID_W: detected-fault count.

Function
REQ-016 The block SHALL implement states IDLE, GOLDEN, RUN, REPORT and DONE.
REQ-017 The IDLE-to-GOLDEN transition SHALL occur on the edge where start=1; start SHALL be ignored in every other state.
REQ-018 On that edge the block SHALL latch batch_start/batch_end, clear det_cnt, clear vector counter c, and clear sig.
REQ-019 During GOLDEN, fault_en SHALL be 0; during RUN, fault_en=1 and fault_id=the current fault.
REQ-020 A pass SHALL last exactly CYCLES cycles, c=0..CYCLES-1, and stim SHALL always equal F(c & ~3).
REQ-021 F(v) bit k SHALL be 0 if v<PH1_END, 1 if v<PH2_END, and else k[0].
REQ-022 At c=0, stim SHALL be all-zero.
REQ-023 Every pass cycle SHALL update sig to {sig[14:0],sig[15]} XOR zero-extended dut_out, sampled at the edge ending that cycle.
REQ-024 At the end of GOLDEN, the final sig SHALL be stored as gold; next state SHALL be RUN with fault=batch_start when batch_start<batch_end, else DONE.
REQ-025 At the end of RUN, the block SHALL enter REPORT with res_valid=1, res_fid=fault, res_sig=final sig, and res_det=(sig!=gold).
REQ-026 The block SHALL increment det_cnt on REPORT entry when res_det=1, saturating at all-ones.
REQ-027 Payload SHALL be held stable while res_valid=1 and res_ready=0.
REQ-028 A transfer SHALL occur on an edge with res_valid=1 and res_ready=1.
REQ-029 On transfer, the block SHALL clear res_valid and increment fault.
REQ-030 After a transfer, if the incremented fault equals batch_end the block SHALL enter DONE; else it SHALL enter RUN with c and sig cleared.
REQ-031 res_ready high before REPORT SHALL have no effect.
REQ-032 The minimum per-fault time SHALL be CYCLES+1 cycles.
REQ-033 busy SHALL be 1 in GOLDEN, RUN and REPORT.
REQ-034 done SHALL be 1 only in DONE.
REQ-035 DONE SHALL hold det_cnt and SHALL move to GOLDEN on start, re-latching the batch bounds.
REQ-036 The fault counter SHALL be FID_W+1 bits so batch_end=2^FID_W-1 terminates without wrap.

Reset
REQ-037 rst=1 SHALL force IDLE from any state, including mid-pass and mid-REPORT.
REQ-038 Reset SHALL clear stim, fault_en, fault_id, res_valid, res_fid, res_sig, res_det, busy, done, det_cnt, c, sig and gold to 0.
REQ-039 No partial result SHALL be emitted after reset.

Verification
REQ-040 Scenario: dut_out=0 constant, batch 0..3 -> 3 results, fids 0,1,2; res_sig=0; res_det=0; det_cnt=0; done after 1+4*512+3 cycles with res_ready=1.
REQ-041 Scenario: model with dut_out=stim for GOLDEN and dut_out=stim^1 when fault_id=5, batch 4..7 -> res_det 0,1,0; det_cnt=1.
REQ-042 Scenario: stim check -> c=0..169 gives 0x000, c=340..343 gives 0x2AA, and 0x3FF before c=340.
REQ-043 Scenario: batch_start=batch_end=9 -> GOLDEN only, then done=1, no res_valid, det_cnt=0.
REQ-044 Scenario: res_ready held 0 for 20 cycles in REPORT -> payload stable, fault_id unchanged; transfer on the 21st edge.
REQ-045 Scenario: rst at c=200 of RUN, and separately in REPORT -> all outputs 0 next cycle; start during busy ignored.
